// File: rtl/micro_sequencer_pkg.sv
// Purpose: stage codes, instruction-class codes and legality check shared by decoder, sequencer and microcode ROM.
// Latency: n/a (types, constants, pure function).
// Backpressure: n/a.
package micro_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd7
    } stage_e;

    localparam logic [4:0] CL_RSVD  = 5'd11;
    localparam logic [4:0] CL_LW    = 5'd20;
    localparam logic [4:0] CL_SW    = 5'd21;
    localparam logic [4:0] CL_JALR  = 5'd22;
    localparam logic [4:0] CL_JAL   = 5'd23;
    localparam logic [4:0] CL_BR    = 5'd24;
    localparam logic [4:0] CL_BRU   = 5'd25;
    localparam logic [4:0] CL_LUI   = 5'd26;
    localparam logic [4:0] CL_AUIPC = 5'd27;

    // Codes above AUIPC and the reserved hole at 11 have no microcode.
    function automatic logic is_legal_class(input logic [4:0] cls);
        return (cls <= CL_AUIPC) && (cls != CL_RSVD);
    endfunction

endpackage

// File: rtl/micro_sequencer_stage_next.sv
// Purpose: per-class stage path table, (class, stage) -> next stage and final-stage flag.
// Latency: purely combinational.
// Backpressure: none; stall and memory waits are applied by the caller.
module stage_next
    import micro_sequencer_pkg::*;
(
    input  logic [4:0] cls,
    input  stage_e     stage,
    output stage_e     next,
    output logic       last
);

    // Path walk; a final stage reports last and points back at IF.
    always_comb begin
        next = ST_IF;
        last = 1'b0;
        case (stage)
            ST_IF: begin
                if (cls == CL_LUI)
                    next = ST_WB;
                else if (cls == CL_JAL || cls == CL_AUIPC)
                    next = ST_EX;
                else
                    next = ST_ID;
            end
            ST_ID: next = ST_EX;
            ST_EX: begin
                if (cls == CL_LW || cls == CL_SW)
                    next = ST_MEM;
                else if (cls == CL_BR || cls == CL_BRU)
                    last = 1'b1;
                else
                    next = ST_WB;
            end
            ST_MEM: begin
                if (cls == CL_LW)
                    next = ST_WB;
                else
                    last = 1'b1;
            end
            ST_WB:   last = 1'b1;
            ST_HALT: next = ST_HALT;
            default: next = ST_IF;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Purpose: multi-cycle stage sequencer feeding {class, stage} to the microcode ROM, with halt, illegal trap and retire count.
// Latency: mc_index/inst_done combinational from state+inputs; stage/flags registered, one cycle per stage.
// Backpressure: stall freezes all state; MEM holds until mem_ready; HALT holds until RST.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int NCLASS = 28,
    parameter int CWIDTH = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [4:0]        inst_class,
    input  logic              stall,
    input  logic              mem_ready,
    input  logic              halt_req,
    output logic [2:0]        stage,
    output logic [7:0]        mc_index,
    output logic              inst_done,
    output logic              illegal,
    output logic              halted,
    output logic [CWIDTH-1:0] retired
);

    stage_e            stage_q, stage_d;
    logic [4:0]        cls_q, cls_d;
    logic              illegal_q, illegal_d;
    logic              halted_q, halted_d;
    logic [CWIDTH-1:0] retired_q;
    logic [4:0]        class_sel;
    logic              legal;
    logic              done;
    stage_e            sn_next;
    logic              sn_last;

    // In IF the decoder output is live; afterwards the latched class drives the ROM.
    always_comb begin
        class_sel = (stage_q == ST_IF) ? inst_class : cls_q;
        legal     = is_legal_class(inst_class) && (int'(inst_class) < NCLASS);
    end

    stage_next u_stage_next (
        .cls   (class_sel),
        .stage (stage_q),
        .next  (sn_next),
        .last  (sn_last)
    );

    // Next-state: stall outranks everything, HALT absorbs, MEM waits on mem_ready.
    always_comb begin
        stage_d   = stage_q;
        cls_d     = cls_q;
        illegal_d = illegal_q;
        halted_d  = halted_q;
        done      = 1'b0;
        if (!stall) begin
            case (stage_q)
                ST_HALT: stage_d = ST_HALT;
                ST_IF: begin
                    cls_d = inst_class;
                    if (!legal) begin
                        stage_d   = ST_HALT;
                        illegal_d = 1'b1;
                        halted_d  = 1'b1;
                    end else begin
                        stage_d = sn_next;
                    end
                end
                default: begin
                    if (stage_q == ST_MEM && !mem_ready) begin
                        stage_d = stage_q;
                    end else if (sn_last) begin
                        done     = 1'b1;
                        stage_d  = halt_req ? ST_HALT : ST_IF;
                        halted_d = halt_req;
                    end else begin
                        stage_d = sn_next;
                    end
                end
            endcase
        end
    end

    // State, latched class, sticky flags and wrapping retire counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stage_q   <= ST_IF;
            cls_q     <= '0;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            stage_q   <= stage_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
            if (done)
                retired_q <= retired_q + 1'b1;
        end
    end

    assign stage     = stage_q;
    assign mc_index  = {class_sel, stage_q};
    assign inst_done = done;
    assign illegal   = illegal_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

    logic       CLK;
    logic       RST;
    logic [4:0] inst_class;
    logic       stall;
    logic       mem_ready;
    logic       halt_req;
    logic [2:0] stage;
    logic [7:0] mc_index;
    logic       inst_done;
    logic       illegal;
    logic       halted;
    logic [2:0] retired;

    micro_sequencer #(.NCLASS(28), .CWIDTH(3)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .inst_class (inst_class),
        .stall      (stall),
        .mem_ready  (mem_ready),
        .halt_req   (halt_req),
        .stage      (stage),
        .mc_index   (mc_index),
        .inst_done  (inst_done),
        .illegal    (illegal),
        .halted     (halted),
        .retired    (retired)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [7:0] idx;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Called at a falling edge with inputs already set: queue the expected
    // stage/index/done for this cycle, compare just after, advance to next falling edge.
    task automatic cyc(input string tag, input logic [2:0] es, input logic [4:0] ec, input logic ed);
        exp_t e;
        sb.push_back('{tag, es, {ec, es}, ed});
        #1;
        e = sb.pop_front();
        chk({e.tag, ".stage"}, {29'd0, stage}, {29'd0, e.st});
        chk({e.tag, ".mc_index"}, {24'd0, mc_index}, {24'd0, e.idx});
        chk({e.tag, ".inst_done"}, {31'd0, inst_done}, {31'd0, e.done});
        @(negedge CLK);
    endtask

    task automatic flags(input string tag, input logic ei, input logic eh, input logic [2:0] er);
        chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, ei});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
        chk({tag, ".retired"}, {29'd0, retired}, {29'd0, er});
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst.stage", {29'd0, stage}, 32'd0);
        chk("rst.inst_done", {31'd0, inst_done}, 32'd0);
        flags("rst", 1'b0, 1'b0, 3'd0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; inst_class = 5'd5; stall = 1'b0; mem_ready = 1'b1; halt_req = 1'b0;
        #3;
        chk("rst.stage", {29'd0, stage}, 32'd0);
        chk("rst.mc_index", {24'd0, mc_index}, {24'd0, 5'd5, 3'd0});
        chk("rst.inst_done", {31'd0, inst_done}, 32'd0);
        flags("rst", 1'b0, 1'b0, 3'd0);
        @(negedge CLK);
        RST = 1'b0;

        // ALU class 0; decoder output changes after IF, latched class must hold.
        inst_class = 5'd0;  cyc("alu.if", 3'd0, 5'd0, 1'b0);
        inst_class = 5'd13; cyc("alu.id", 3'd1, 5'd0, 1'b0);
        cyc("alu.ex", 3'd2, 5'd0, 1'b0);
        cyc("alu.wb", 3'd4, 5'd0, 1'b1);
        flags("alu", 1'b0, 1'b0, 3'd1);

        // LW with three memory wait cycles; mem_ready low outside MEM is ignored.
        inst_class = 5'd20; mem_ready = 1'b0;
        cyc("lw.if", 3'd0, 5'd20, 1'b0);
        cyc("lw.id", 3'd1, 5'd20, 1'b0);
        cyc("lw.ex", 3'd2, 5'd20, 1'b0);
        for (int i = 0; i < 3; i++) cyc("lw.memwait", 3'd3, 5'd20, 1'b0);
        mem_ready = 1'b1;
        cyc("lw.mem", 3'd3, 5'd20, 1'b0);
        cyc("lw.wb", 3'd4, 5'd20, 1'b1);
        flags("lw", 1'b0, 1'b0, 3'd2);

        // Back-to-back LUI, JAL, branch.
        inst_class = 5'd26; cyc("lui.if", 3'd0, 5'd26, 1'b0);
        cyc("lui.wb", 3'd4, 5'd26, 1'b1);
        inst_class = 5'd23; cyc("jal.if", 3'd0, 5'd23, 1'b0);
        cyc("jal.ex", 3'd2, 5'd23, 1'b0);
        cyc("jal.wb", 3'd4, 5'd23, 1'b1);
        inst_class = 5'd24; cyc("br.if", 3'd0, 5'd24, 1'b0);
        cyc("br.id", 3'd1, 5'd24, 1'b0);
        cyc("br.ex", 3'd2, 5'd24, 1'b1);
        flags("b2b", 1'b0, 1'b0, 3'd5);

        // SW ends in MEM; stall there suppresses inst_done even with mem_ready.
        inst_class = 5'd21; cyc("sw.if", 3'd0, 5'd21, 1'b0);
        cyc("sw.id", 3'd1, 5'd21, 1'b0);
        cyc("sw.ex", 3'd2, 5'd21, 1'b0);
        stall = 1'b1; mem_ready = 1'b1; cyc("sw.memstall", 3'd3, 5'd21, 1'b0);
        stall = 1'b0; mem_ready = 1'b0; cyc("sw.memwait", 3'd3, 5'd21, 1'b0);
        mem_ready = 1'b1; cyc("sw.mem", 3'd3, 5'd21, 1'b1);
        flags("sw", 1'b0, 1'b0, 3'd6);

        // Two LUIs take the 3-bit counter through its wrap.
        inst_class = 5'd26;
        for (int i = 0; i < 2; i++) begin
            cyc("wrap.if", 3'd0, 5'd26, 1'b0);
            cyc("wrap.wb", 3'd4, 5'd26, 1'b1);
        end
        flags("wrap", 1'b0, 1'b0, 3'd0);

        // halt_req in EX: instruction completes, then HALT absorbs.
        inst_class = 5'd0; cyc("hlt.if", 3'd0, 5'd0, 1'b0);
        cyc("hlt.id", 3'd1, 5'd0, 1'b0);
        halt_req = 1'b1; cyc("hlt.ex", 3'd2, 5'd0, 1'b0);
        cyc("hlt.wb", 3'd4, 5'd0, 1'b1);
        halt_req = 1'b0; inst_class = 5'd26;
        cyc("hlt.halt", 3'd7, 5'd0, 1'b0);
        cyc("hlt.absorb", 3'd7, 5'd0, 1'b0);
        flags("hlt", 1'b0, 1'b1, 3'd1);
        do_reset();

        // Stall two cycles in EX with halt_req high.
        inst_class = 5'd12; cyc("stl.if", 3'd0, 5'd12, 1'b0);
        cyc("stl.id", 3'd1, 5'd12, 1'b0);
        stall = 1'b1; halt_req = 1'b1;
        cyc("stl.ex0", 3'd2, 5'd12, 1'b0);
        cyc("stl.ex1", 3'd2, 5'd12, 1'b0);
        stall = 1'b0;
        cyc("stl.ex", 3'd2, 5'd12, 1'b0);
        cyc("stl.wb", 3'd4, 5'd12, 1'b1);
        halt_req = 1'b0;
        cyc("stl.halt", 3'd7, 5'd12, 1'b0);
        flags("stl", 1'b0, 1'b1, 3'd1);
        do_reset();

        // Illegal class 11: stall delays the trap, then sticky HALT.
        inst_class = 5'd11; stall = 1'b1;
        cyc("ill.stall", 3'd0, 5'd11, 1'b0);
        flags("ill.stall", 1'b0, 1'b0, 3'd0);
        stall = 1'b0;
        cyc("ill.if", 3'd0, 5'd11, 1'b0);
        inst_class = 5'd0;
        cyc("ill.halt", 3'd7, 5'd11, 1'b0);
        cyc("ill.sticky", 3'd7, 5'd11, 1'b0);
        flags("ill", 1'b1, 1'b1, 3'd0);
        do_reset();

        // Codes 28..31 also trap.
        inst_class = 5'd30; cyc("ill30.if", 3'd0, 5'd30, 1'b0);
        cyc("ill30.halt", 3'd7, 5'd30, 1'b0);
        flags("ill30", 1'b1, 1'b1, 3'd0);
        do_reset();

        // Clean restart after reset.
        inst_class = 5'd27; cyc("aui.if", 3'd0, 5'd27, 1'b0);
        cyc("aui.ex", 3'd2, 5'd27, 1'b0);
        cyc("aui.wb", 3'd4, 5'd27, 1'b1);
        flags("aui", 1'b0, 1'b0, 3'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Multi-cycle control sequencer that drives the stage and index inputs of the microcode control ROM. Each instruction class follows its own stage path through IF, ID, EX, MEM and WB. The block tracks the current stage, latches the instruction class, and handles data-memory wait states and halt requests. It also counts retired instructions. It sits between the instruction decoder and the microcode ROM in the multi-cycle RISC-V core.

## Interface
- `NCLASS`, default 28: number of legal class codes, 0..27. Codes 11 and 28..31 are illegal.
- `CWIDTH`, default 32: width of the retired-instruction counter.
- `CLK`  in  1  clock; all state updates on its rising edge.
- `RST`  in  1  reset, asynchronous and active-high.
- `inst_class`  in  5  class code, decoded combinationally from the instruction-memory read data; valid throughout IF.
- `stall`  in  1  global freeze; holds all state.
- `mem_ready`  in  1  data-memory done; sampled only in MEM.
- `halt_req`  in  1  request to stop at the next instruction boundary.
- `stage`  out  3  current stage: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=7.
- `mc_index`  out  8  microcode ROM address `{class_sel, stage}`.
- `inst_done`  out  1  one-cycle pulse in the final stage of an instruction, on the cycle it advances.
- `illegal`  out  1  sticky flag for an illegal class.
- `halted`  out  1  high while in HALT.
- `retired`  out  `CWIDTH`  count of completed instructions.

## Operation
- `class_sel` is `inst_class` while stage is IF; otherwise it is the latched class `cls_q`.
- `cls_q` loads `inst_class` on the IF→next transition.
- Stage paths by class:
  - 0–9 and 10, 12–19 (R/I ALU), 22 (JALR): IF→ID→EX→WB.
  - 20 (LW): IF→ID→EX→MEM→WB.
  - 21 (SW): IF→ID→EX→MEM.
  - 23 (JAL), 27 (AUIPC): IF→EX→WB.
  - 24, 25 (branch): IF→ID→EX.
  - 26 (LUI): IF→WB.
- After the final stage of a path, the next stage is IF, or HALT if `halt_req` is high in that cycle.
- Illegal class: detected in IF. The next stage is HALT and `illegal` sets. `inst_done` does not pulse and `retired` does not increment.
- In MEM with `mem_ready`=0, the stage stays MEM. `inst_done` is held off until the final stage advances.
- HALT is absorbing; only `RST` exits it. In HALT, `mc_index` = `{cls_q, 3'b111}`.
- `retired` increments on each `inst_done` and wraps modulo 2^`CWIDTH` with no flag.
- `stall`=1 freezes stage, `cls_q`, `retired` and flags, and forces `inst_done`=0. Stall has priority over `mem_ready`, `halt_req` and the illegal check; an event sampled while stalled is re-evaluated on the first unstalled cycle.

## Timing
- Reset values: stage=IF, `cls_q`=0, `retired`=0, `illegal`=0, `halted`=0, `inst_done`=0. `mc_index` = `{inst_class, 3'b000}` is combinational.
- Deasserting reset mid-instruction always restarts at IF.
- Every stage lasts one cycle unless stalled or waiting on memory.
- Cycles per instruction with no stalls: ALU/JALR 4, LW 5, SW 4, JAL/AUIPC 3, branch 3, LUI 2.
- `stage`, `halted` and `illegal` are registered outputs. `mc_index` and `inst_done` are combinational from registered state plus inputs; there is no added latency to the ROM.
- `halt_req` is level-sensitive and sampled only in a final stage. If it is asserted mid-instruction, the instruction completes first.

## Structure
- Shared package holds:
  - Stage constants `ST_IF`, `ST_ID`, `ST_EX`, `ST_MEM`, `ST_WB`, `ST_HALT`.
  - Class code constants (`CL_LW`=20, `CL_SW`=21, `CL_JALR`=22, `CL_JAL`=23, `CL_BR`=24, `CL_BRU`=25, `CL_LUI`=26, `CL_AUIPC`=27).
  - The `is_legal_class` function.
  - These are used by the decoder and the microcode ROM as well.
- One sub-module, `stage_next`: purely combinational, (class, stage) → next stage plus last-stage flag.
- The top level holds the registers, counter and stall/halt muxing.

## Test plan
- Reset, then class 0 with no stalls → stage 0,1,2,4,0; `mc_index` 0x00,0x01,0x02,0x04,0x00; `inst_done` high in WB; `retired`=1.
- Class 20 with `mem_ready`=0 for 3 MEM cycles → stage stays 3 for 4 cycles, then WB, then `retired`++; 8 cycles in total.
- Back-to-back classes 26, 23, 24 → stage sequences 0,4 | 0,2,4 | 0,1,2; `mc_index` in IF equals `{inst_class,000}`; `retired`=3 after 8 cycles.
- Class 11 in IF → next stage 7; `illegal`=1 and `halted`=1 sticky; `retired` unchanged; RST clears both.
- `halt_req` raised in the EX of class 0 → WB completes, `retired`++, then stage 7.
- `stall` held 2 cycles in EX with `halt_req` high → stage holds 2 with no `inst_done` pulse, then WB, then stage 7.
